// File: rtl/nubus_master.sv
// Card-side NuBus initiator: arbitrates for the bus, runs the START cycle, and
// waits in the data cycle for ACK or timeout, generating transceiver strobes.
module nubus_master #(
  parameter int TMO_BITS = 8
) (
  input  logic clk,
  input  logic resetn,
  input  logic mem_valid,
  input  logic mem_write,
  output logic mem_ready,
  output logic mem_error,
  input  logic slave,
  input  logic arb_won,
  input  logic nub_startn,
  input  logic nub_ackn,
  input  logic nub_tm0n,
  input  logic nub_tm1n,
  output logic rqst_o,
  output logic start_o,
  output logic master,
  output logic mtm1n,
  output logic arbcy,
  output logic adrcy,
  output logic dtacy
);

  typedef enum logic [2:0] {IDLE, ARB, ADDR, DATA, DONE} state_t;

  state_t               state, state_nx;
  logic                 busy;
  logic                 err;
  logic [TMO_BITS-1:0]  cnt;
  logic [TMO_BITS-1:0]  cnt_inc;
  logic                 tmo;
  logic                 ack;

  assign ack     = !nub_ackn;
  assign cnt_inc = cnt + TMO_BITS'(1);
  // Timeout fires on the cycle the counter would reach all-ones.
  assign tmo     = (cnt_inc == '1);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  // Another master's START marks the bus busy until the matching ACK.
  always_ff @(posedge clk) begin
    if (!resetn)                      busy <= 1'b0;
    else if (!nub_startn && !start_o) busy <= 1'b1;
    else if (ack)                     busy <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt   <= '0;
      err   <= 1'b0;
      mtm1n <= 1'b1;
    end else begin
      if (state == IDLE && mem_valid && !slave) mtm1n <= mem_write;
      if (state == ADDR) cnt <= '0;
      if (state == DATA) begin
        cnt <= cnt_inc;
        // ACK takes priority over a simultaneous timeout; only status 11 is good.
        if (ack)      err <= !(nub_tm1n && nub_tm0n);
        else if (tmo) err <= 1'b1;
      end
    end
  end

  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (mem_valid && !slave)                state_nx = ARB;
      ARB:  if (arb_won && !busy && nub_startn)     state_nx = ADDR;
      ADDR:                                         state_nx = DATA;
      DATA: if (ack || tmo)                         state_nx = DONE;
      DONE:                                         state_nx = IDLE;
      default:                                      state_nx = IDLE;
    endcase
  end

  always_comb begin
    rqst_o    = 1'b0;
    start_o   = 1'b0;
    master    = 1'b0;
    arbcy     = 1'b0;
    adrcy     = 1'b0;
    dtacy     = 1'b0;
    mem_ready = 1'b0;
    mem_error = 1'b0;
    unique case (state)
      ARB: begin
        arbcy  = 1'b1;
        rqst_o = 1'b1;
      end
      ADDR: begin
        start_o = 1'b1;
        adrcy   = 1'b1;
        master  = 1'b1;
      end
      DATA: begin
        dtacy  = 1'b1;
        master = 1'b1;
      end
      DONE: begin
        mem_ready = 1'b1;
        mem_error = err;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_nubus_master.sv
// Scoreboard bench for nubus_master: expected completion status is queued when a
// request is issued and compared when mem_ready pulses.
module tb_nubus_master;

  localparam int TMO_BITS = 4;
  localparam int TMO_CYC  = (1 << TMO_BITS) - 1;

  logic clk = 1'b0;
  logic resetn, mem_valid, mem_write, mem_ready, mem_error, slave, arb_won;
  logic nub_startn, nub_ackn, nub_tm0n, nub_tm1n;
  logic rqst_o, start_o, master, mtm1n, arbcy, adrcy, dtacy;

  int n_cmp = 0;
  int n_mis = 0;
  bit exp_q[$];

  nubus_master #(.TMO_BITS(TMO_BITS)) dut (
    .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .mem_write(mem_write),
    .mem_ready(mem_ready), .mem_error(mem_error), .slave(slave), .arb_won(arb_won),
    .nub_startn(nub_startn), .nub_ackn(nub_ackn), .nub_tm0n(nub_tm0n),
    .nub_tm1n(nub_tm1n), .rqst_o(rqst_o), .start_o(start_o), .master(master),
    .mtm1n(mtm1n), .arbcy(arbcy), .adrcy(adrcy), .dtacy(dtacy)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] outs();
    return {rqst_o, start_o, master, mtm1n, arbcy, adrcy, dtacy, mem_ready, mem_error};
  endfunction

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (outs() !== 9'b000100000) begin
      n_mis++;
      $display("FAIL reset_outputs got=%b want=%b", outs(), 9'b000100000);
    end
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (outs() !== 9'b000100000) begin
      n_mis++;
      $display("FAIL idle_outputs got=%b want=%b", outs(), 9'b000100000);
    end
  endtask

  // Issues one request, acks on DATA cycle ack_at (0 = never), checks strobe
  // counts against the expected sequence and the queued completion status.
  task automatic run_txn(input bit wr, input int ack_at, input logic [1:0] st,
                         input int exp_arb, input string name);
    bit acked   = (ack_at >= 1 && ack_at <= TMO_CYC);
    bit exp_err = acked ? (st != 2'b11) : 1'b1;
    int exp_dt  = acked ? ack_at : TMO_CYC;
    int n_arb = 0, n_adr = 0, n_dt = 0, n_st = 0, bad_hot = 0, bad_mtm = 0;
    bit done = 1'b0;
    int got[6];
    int want[6];
    exp_q.push_back(exp_err);
    mem_write = wr;
    mem_valid = 1'b1;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      @(negedge clk);
      n_arb += int'(arbcy);
      n_adr += int'(adrcy);
      n_st  += int'(start_o);
      if ((int'(arbcy) + int'(adrcy) + int'(dtacy)) > 1 || master !== (adrcy | dtacy))
        bad_hot++;
      if ((arbcy | adrcy | dtacy) && mtm1n !== wr) bad_mtm++;
      nub_ackn = 1'b1;
      if (dtacy) begin
        n_dt++;
        if (n_dt == ack_at) begin
          nub_ackn = 1'b0;
          {nub_tm1n, nub_tm0n} = st;
        end
      end
      if (mem_ready) begin
        done = 1'b1;
        mem_valid = 1'b0;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_mis++;
          $display("FAIL %s_sb_empty got=%b want=none", name, mem_error);
        end else if (mem_error !== exp_q[0]) begin
          n_mis++;
          $display("FAIL %s_mem_error got=%b want=%b", name, mem_error, exp_q[0]);
          void'(exp_q.pop_front());
        end else begin
          void'(exp_q.pop_front());
        end
      end
    end
    nub_ackn = 1'b1;
    {nub_tm1n, nub_tm0n} = 2'b11;
    n_cmp++;
    if (!done) begin
      n_mis++;
      $display("FAIL %s_no_ready got=0 want=1", name);
      mem_valid = 1'b0;
      exp_q.delete();
    end
    got  = '{n_arb, n_adr, n_st, n_dt, bad_hot, bad_mtm};
    want = '{exp_arb, 1, 1, exp_dt, 0, 0};
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (got[i] != want[i]) begin
        n_mis++;
        $display("FAIL %s_count%0d got=%0d want=%0d", name, i, got[i], want[i]);
      end
    end
    @(negedge clk);
    n_cmp++;
    if ({arbcy, adrcy, dtacy, master, mem_ready, mem_error, mtm1n} !== {6'b0, wr}) begin
      n_mis++;
      $display("FAIL %s_after_done got=%b want=%b", name,
               {arbcy, adrcy, dtacy, master, mem_ready, mem_error, mtm1n}, {6'b0, wr});
    end
  endtask

  task automatic test_write_basic();
    run_txn(1'b1, 2, 2'b11, 1, "write_basic");
  endtask

  task automatic test_slave_block();
    int bad = 0;
    slave = 1'b1;
    mem_write = 1'b0;
    mem_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (arbcy | master | mem_ready | rqst_o) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_mis++;
      $display("FAIL slave_block got=%0d want=0", bad);
    end
    slave = 1'b0;
    run_txn(1'b0, 1, 2'b10, 1, "slave_read");
  endtask

  task automatic test_busy();
    int bad = 0;
    bit seen = 1'b0;
    bit done = 1'b0;
    exp_q.push_back(1'b0);
    arb_won = 1'b0;
    mem_write = 1'b0;
    mem_valid = 1'b1;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = arbcy;
    end
    n_cmp++;
    if (!seen) begin
      n_mis++;
      $display("FAIL busy_arb got=0 want=1");
    end
    nub_startn = 1'b0;
    arb_won = 1'b1;
    @(negedge clk);
    nub_startn = 1'b1;
    repeat (4) begin
      if (start_o) bad++;
      @(negedge clk);
    end
    nub_ackn = 1'b0;
    if (start_o) bad++;
    @(negedge clk);
    nub_ackn = 1'b1;
    if (start_o || !arbcy) bad++;
    n_cmp++;
    if (bad != 0) begin
      n_mis++;
      $display("FAIL busy_hold got=%0d want=0", bad);
    end
    @(negedge clk);
    n_cmp++;
    if (start_o !== 1'b1) begin
      n_mis++;
      $display("FAIL busy_start got=%b want=1", start_o);
    end
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      nub_ackn = !dtacy;
      if (mem_ready) begin
        done = 1'b1;
        mem_valid = 1'b0;
        n_cmp++;
        if (exp_q.size() == 0 || mem_error !== exp_q[0]) begin
          n_mis++;
          $display("FAIL busy_mem_error got=%b want=0", mem_error);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
    end
    nub_ackn = 1'b1;
    n_cmp++;
    if (!done) begin
      n_mis++;
      $display("FAIL busy_no_ready got=0 want=1");
      mem_valid = 1'b0;
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    run_txn(1'b1, 0, 2'b11, 1, "timeout");
  endtask

  task automatic test_saturation();
    run_txn(1'b0, TMO_CYC, 2'b11, 1, "sat_ack_ok");
    run_txn(1'b1, TMO_CYC - 1, 2'b00, 1, "late_ack_err");
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    int bad = 0;
    exp_q.push_back(1'b0);
    mem_write = 1'b0;
    mem_valid = 1'b1;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = dtacy;
    end
    n_cmp++;
    if (!seen) begin
      n_mis++;
      $display("FAIL rst_mid_data got=0 want=1");
    end
    resetn = 1'b0;
    mem_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (outs() !== 9'b000100000) begin
      n_mis++;
      $display("FAIL rst_mid_outputs got=%b want=%b", outs(), 9'b000100000);
    end
    resetn = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (mem_ready | master | arbcy) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_mis++;
      $display("FAIL rst_mid_quiet got=%0d want=0", bad);
    end
    // The aborted request is never acknowledged.
    exp_q.delete();
    run_txn(1'b1, 3, 2'b11, 1, "post_reset");
  endtask

  task automatic test_back_to_back();
    int nready = 0, rdy_cyc = -1, arb2 = -1;
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    mem_write = 1'b1;
    mem_valid = 1'b1;
    for (int cyc = 0; cyc < 100 && nready < 2; cyc++) begin
      @(negedge clk);
      nub_ackn = !dtacy;
      {nub_tm1n, nub_tm0n} = (nready == 0) ? 2'b11 : 2'b01;
      if (nready == 1 && arbcy && arb2 < 0) arb2 = cyc;
      if (mem_ready) begin
        n_cmp++;
        if (exp_q.size() == 0 || mem_error !== exp_q[0]) begin
          n_mis++;
          $display("FAIL b2b_mem_error%0d got=%b", nready, mem_error);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        nready++;
        if (nready == 1) rdy_cyc = cyc;
        if (nready == 2) mem_valid = 1'b0;
      end
    end
    nub_ackn = 1'b1;
    {nub_tm1n, nub_tm0n} = 2'b11;
    mem_valid = 1'b0;
    n_cmp++;
    if (nready != 2) begin
      n_mis++;
      $display("FAIL b2b_count got=%0d want=2", nready);
    end
    n_cmp++;
    if (rdy_cyc < 0 || arb2 != rdy_cyc + 2) begin
      n_mis++;
      $display("FAIL b2b_idle_gap got=%0d want=%0d", arb2, rdy_cyc + 2);
    end
    @(negedge clk);
  endtask

  initial begin
    resetn = 1'b0; mem_valid = 1'b0; mem_write = 1'b0; slave = 1'b0; arb_won = 1'b1;
    nub_startn = 1'b1; nub_ackn = 1'b1; nub_tm0n = 1'b1; nub_tm1n = 1'b1;
    test_reset();
    test_write_basic();
    test_slave_block();
    test_busy();
    test_timeout();
    test_saturation();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
